// File: rtl/retire_trace_checker.sv
// rtl/retire_trace_checker.sv - compares retired register writes against a buffered golden trace
module retire_trace_checker #(
  parameter int FIFO_DEPTH  = 8,
  parameter bit CHECK_WDATA = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic [69:0] inst_retire,
  input  logic        chk_start,
  input  logic        chk_finish,
  input  logic        gold_valid,
  input  logic [68:0] gold_data,
  output logic        gold_ready,
  output logic [1:0]  chk_state,
  output logic [1:0]  err_code,
  output logic [31:0] match_cnt,
  output logic [31:0] err_pc,
  output logic [31:0] exp_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [68:0] mem [FIFO_DEPTH];
  logic        fin_pend, fin_pend_nx, fin_eff, rdy_en;
  logic [1:0]  err_nx;
  logic [31:0] cnt_nx, epc_nx, xpc_nx;

  logic        empty, full, push, ev, hit;
  logic [68:0] head;
  logic [31:0] r_pc, r_wdata;
  logic [4:0]  r_waddr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // rdy_en keeps gold_ready low through reset and raises it on the first edge after release
  assign gold_ready = rdy_en && ((state == S_IDLE) || (state == S_RUN)) && !full;
  assign push       = gold_valid && gold_ready;

  assign r_pc    = inst_retire[31:0];
  assign r_wdata = inst_retire[63:32];
  assign r_waddr = inst_retire[68:64];
  assign ev      = inst_retire[69] && (r_waddr != 5'd0);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign hit     = (r_pc == head[31:0]) && (r_waddr == head[36:32]) &&
                   (!CHECK_WDATA || (r_wdata == head[68:37]));

  always_comb begin
    state_nx    = state;
    rd_ptr_nx   = rd_ptr;
    fin_pend_nx = fin_pend;
    fin_eff     = 1'b0;
    err_nx      = err_code;
    cnt_nx      = match_cnt;
    epc_nx      = err_pc;
    xpc_nx      = exp_pc;
    case (state)
      S_IDLE: if (chk_start) state_nx = S_RUN;
      S_RUN: begin
        fin_eff = chk_finish || fin_pend;
        if (ev) begin
          // retire wins; a coincident finish is deferred one cycle
          fin_pend_nx = fin_eff;
          if (empty) begin
            state_nx = S_FAIL;
            err_nx   = 2'd2;
            epc_nx   = r_pc;
            xpc_nx   = 32'd0;
          end else begin
            rd_ptr_nx = rd_ptr + (AW+1)'(1);
            if (hit) begin
              cnt_nx = match_cnt + 32'd1;
            end else begin
              state_nx = S_FAIL;
              err_nx   = 2'd1;
              epc_nx   = r_pc;
              xpc_nx   = head[31:0];
            end
          end
        end else if (fin_eff) begin
          fin_pend_nx = 1'b0;
          if (empty) begin
            state_nx = S_PASS;
          end else begin
            state_nx = S_FAIL;
            err_nx   = 2'd3;
            epc_nx   = 32'd0;
            xpc_nx   = head[31:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fin_pend  <= 1'b0;
      rdy_en    <= 1'b0;
      err_code  <= 2'd0;
      match_cnt <= 32'd0;
      err_pc    <= 32'd0;
      exp_pc    <= 32'd0;
    end else begin
      state     <= state_nx;
      rd_ptr    <= rd_ptr_nx;
      fin_pend  <= fin_pend_nx;
      rdy_en    <= 1'b1;
      err_code  <= err_nx;
      match_cnt <= cnt_nx;
      err_pc    <= epc_nx;
      exp_pc    <= xpc_nx;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
    end
  end

  // storage is not reset; only the pointers define what is buffered
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= gold_data;
  end

  assign chk_state = state;

endmodule

// File: tb/tb_retire_trace_checker.sv
// tb/tb_retire_trace_checker.sv - directed scoreboard bench for retire_trace_checker
module tb_retire_trace_checker;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic [69:0] inst_retire = '0;
  logic        chk_start = 1'b0, chk_finish = 1'b0, gold_valid = 1'b0;
  logic [68:0] gold_data = '0;
  logic        gold_ready, nw_gold_ready;
  logic [1:0]  chk_state, err_code, nw_chk_state, nw_err_code;
  logic [31:0] match_cnt, err_pc, exp_pc, nw_match_cnt, nw_err_pc, nw_exp_pc;

  always #5 sys_clk = ~sys_clk;

  retire_trace_checker #(.FIFO_DEPTH(8), .CHECK_WDATA(1'b1)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .inst_retire(inst_retire),
    .chk_start(chk_start), .chk_finish(chk_finish), .gold_valid(gold_valid),
    .gold_data(gold_data), .gold_ready(gold_ready), .chk_state(chk_state),
    .err_code(err_code), .match_cnt(match_cnt), .err_pc(err_pc), .exp_pc(exp_pc)
  );

  retire_trace_checker #(.FIFO_DEPTH(8), .CHECK_WDATA(1'b0)) dut_nw (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .inst_retire(inst_retire),
    .chk_start(chk_start), .chk_finish(chk_finish), .gold_valid(gold_valid),
    .gold_data(gold_data), .gold_ready(nw_gold_ready), .chk_state(nw_chk_state),
    .err_code(nw_err_code), .match_cnt(nw_match_cnt), .err_pc(nw_err_pc), .exp_pc(nw_exp_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t        gq[$];
  int          checks = 0, errors = 0;
  int          m_state = 0;
  logic [1:0]  m_code = 0;
  logic [31:0] m_cnt = 0, m_epc = 0, m_xpc = 0;
  logic        m_pend = 0, m_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_rdy;
    exp_rdy = m_rdy && (m_state <= 1) && (gq.size() < 8);
    chk({tag, ".state"}, 32'(chk_state), 32'(m_state));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, ".match_cnt"}, match_cnt, m_cnt);
    chk({tag, ".err_pc"}, err_pc, m_epc);
    chk({tag, ".exp_pc"}, exp_pc, m_xpc);
    chk({tag, ".gold_ready"}, 32'(gold_ready), 32'(exp_rdy));
  endtask

  task automatic m_fail(input logic [1:0] code, input logic [31:0] epc, input logic [31:0] xpc);
    m_state = 3;
    m_code  = code;
    m_epc   = epc;
    m_xpc   = xpc;
  endtask

  // One clock with the given inputs; the model is stepped from pre-edge state.
  task automatic cyc(input string tag, input logic rv, input logic [31:0] rpc, input logic [4:0] rwa,
                     input logic [31:0] rwd, input logic fin, input logic st, input logic gv,
                     input logic [31:0] gpc, input logic [4:0] gwa, input logic [31:0] gwd);
    logic accept, fin_eff;
    ent_t h;
    inst_retire = {rv, rwa, rwd, rpc};
    chk_finish  = fin;
    chk_start   = st;
    gold_valid  = gv;
    gold_data   = {gwd, gwa, gpc};
    accept = gv && m_rdy && (m_state <= 1) && (gq.size() < 8);
    if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 1) begin
      fin_eff = fin || m_pend;
      if (rv && rwa != 5'd0) begin
        m_pend = fin_eff;
        if (gq.size() == 0) m_fail(2'd2, rpc, 32'd0);
        else begin
          h = gq.pop_front();
          if (h.pc == rpc && h.wa == rwa && h.wd == rwd) m_cnt = m_cnt + 32'd1;
          else m_fail(2'd1, rpc, h.pc);
        end
      end else if (fin_eff) begin
        m_pend = 1'b0;
        if (gq.size() == 0) m_state = 2;
        else m_fail(2'd3, 32'd0, gq[0].pc);
      end
    end
    if (accept) gq.push_back('{pc: gpc, wa: gwa, wd: gwd});
    @(posedge sys_clk);
    #1;
    inst_retire = '0;
    chk_finish  = 1'b0;
    chk_start   = 1'b0;
    gold_valid  = 1'b0;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    cyc(tag, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, pc, wa, wd);
  endtask

  task automatic ret(input string tag, input logic en, input logic [31:0] pc, input logic [4:0] wa,
                     input logic [31:0] wd, input logic fin);
    cyc(tag, en, pc, wa, wd, fin, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic ctl(input string tag, input logic st, input logic fin);
    cyc(tag, 1'b0, 0, 0, 0, fin, st, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    sys_reset_n = 1'b0;
    #2;
    gq.delete();
    m_state = 0; m_code = 0; m_cnt = 0; m_epc = 0; m_xpc = 0; m_pend = 0; m_rdy = 0;
    check_all({tag, ".in_reset"});
    #2;
    sys_reset_n = 1'b1;
    @(posedge sys_clk);
    #1;
    m_rdy = 1'b1;
    check_all({tag, ".released"});
  endtask

  initial begin
    @(posedge sys_clk);
    #1;
    do_reset("rst0");

    // preload, ignored retires, coincident finish
    push("t1.p0", 32'h0, 5'd1, 32'h11);
    push("t1.p1", 32'h4, 5'd2, 32'h22);
    push("t1.p2", 32'h8, 5'd3, 32'h33);
    ret("t1.idle_ret", 1'b1, 32'h0, 5'd1, 32'h11, 1'b0);
    ctl("t1.start", 1'b1, 1'b0);
    ctl("t1.restart", 1'b1, 1'b0);
    ret("t1.r0", 1'b1, 32'h0, 5'd1, 32'h11, 1'b0);
    ret("t1.wa0", 1'b1, 32'h4, 5'd0, 32'h22, 1'b0);
    ret("t1.en0", 1'b0, 32'h4, 5'd2, 32'h22, 1'b0);
    ret("t1.r1", 1'b1, 32'h4, 5'd2, 32'h22, 1'b0);
    ret("t1.r2fin", 1'b1, 32'h8, 5'd3, 32'h33, 1'b1);
    chk("t1.defer_state", 32'(chk_state), 32'd1);
    ctl("t1.pass", 1'b0, 1'b0);
    chk("t1.pass_state", 32'(chk_state), 32'd2);
    chk("t1.pass_cnt", match_cnt, 32'd3);
    ctl("t1.start_in_pass", 1'b1, 1'b1);

    // wdata mismatch; the CHECK_WDATA=0 instance must still match
    do_reset("rst1");
    push("t2.p0", 32'h0, 5'd1, 32'h11);
    push("t2.p1", 32'h4, 5'd2, 32'h22);
    ctl("t2.start", 1'b1, 1'b0);
    ret("t2.r0", 1'b1, 32'h0, 5'd1, 32'h11, 1'b0);
    ret("t2.r1bad", 1'b1, 32'h4, 5'd2, 32'h23, 1'b0);
    chk("t2.code", 32'(err_code), 32'd1);
    chk("t2.err_pc", err_pc, 32'h4);
    chk("t2.exp_pc", exp_pc, 32'h4);
    chk("t2.nw_state", 32'(nw_chk_state), 32'd1);
    chk("t2.nw_cnt", nw_match_cnt, 32'd2);
    chk("t2.nw_code", 32'(nw_err_code), 32'd0);
    chk("t2.nw_err_pc", nw_err_pc, 32'd0);
    chk("t2.nw_exp_pc", nw_exp_pc, 32'd0);
    chk("t2.nw_ready", 32'(nw_gold_ready), 32'd1);
    ret("t2.frozen", 1'b1, 32'h8, 5'd3, 32'h33, 1'b1);

    // underflow
    do_reset("rst2");
    ctl("t3.start", 1'b1, 1'b0);
    ret("t3.under", 1'b1, 32'h100, 5'd5, 32'h0, 1'b0);
    chk("t3.code", 32'(err_code), 32'd2);
    chk("t3.err_pc", err_pc, 32'h100);

    // full FIFO, simultaneous push/pop, leftover at finish
    do_reset("rst3");
    for (int i = 0; i < 8; i++) push("t4.fill", 32'(i * 4), 5'(i + 1), 32'(i));
    chk("t4.full_ready", 32'(gold_ready), 32'd0);
    push("t4.over", 32'h200, 5'd9, 32'h9);
    ctl("t4.start", 1'b1, 1'b0);
    ret("t4.r0", 1'b1, 32'h0, 5'd1, 32'h0, 1'b0);
    chk("t4.ready_back", 32'(gold_ready), 32'd1);
    cyc("t4.r1push", 1'b1, 32'h4, 5'd2, 32'h1, 1'b0, 1'b0, 1'b1, 32'h100, 5'd7, 32'h77);
    for (int i = 2; i < 7; i++) ret("t4.rn", 1'b1, 32'(i * 4), 5'(i + 1), 32'(i), 1'b0);
    ctl("t4.fin", 1'b0, 1'b1);
    chk("t4.code", 32'(err_code), 32'd3);
    chk("t4.exp_pc", exp_pc, 32'h1c);

    // reset mid-RUN discards buffered entries
    do_reset("rst4");
    for (int i = 0; i < 4; i++) push("t5.fill", 32'(i * 4), 5'(i + 1), 32'(i));
    ctl("t5.start", 1'b1, 1'b0);
    ret("t5.r0", 1'b1, 32'h0, 5'd1, 32'h0, 1'b0);
    do_reset("t5.rst");
    chk("t5.cnt", match_cnt, 32'd0);
    ctl("t5.start2", 1'b1, 1'b0);
    ctl("t5.fin", 1'b0, 1'b1);
    chk("t5.pass", 32'(chk_state), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
